// File: rtl/hazard_unit.sv
// Central pipeline sequencer: load-use bubble, taken-branch flush and multi-cycle MEM freeze.
// Stage controls are Mealy (state + live inputs); state, wait counter and stall counter are registered.
module hazard_unit #(
  parameter int unsigned MEM_TIMEOUT         = 255,
  parameter int unsigned CNT_WIDTH           = 16,
  parameter int unsigned REG_FILE_ADDR_WIDTH = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] id_reg_1_idx,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] id_reg_2_idx,
  input  logic                           id_uses_reg_1,
  input  logic                           id_uses_reg_2,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] ex_reg_dest_idx,
  input  logic                           ex_mem_read,
  input  logic                           ex_no_op,
  input  logic                           branch_taken,
  input  logic                           mem_stall_req,
  input  logic                           mem_ready,
  output logic                           pc_hold,
  output logic [1:0]                     if_id_hazard,
  output logic [1:0]                     id_ex_hazard,
  output logic [1:0]                     ex_mem_hazard,
  output logic [1:0]                     mem_wb_hazard,
  output logic                           mem_timeout,
  output logic [CNT_WIDTH-1:0]           stall_cycles
);

  localparam int unsigned HAZD_HOLD_BIT  = 0;
  localparam int unsigned HAZD_NO_OP_BIT = 1;
  localparam int unsigned WAIT_W         = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [1:0]  HZ_HOLD        = 2'(1 << HAZD_HOLD_BIT);
  localparam logic [1:0]  HZ_NO_OP       = 2'(1 << HAZD_NO_OP_BIT);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD_USE,
    ST_FLUSH,
    ST_MEM_WAIT
  } state_e;

  state_e                state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [CNT_WIDTH-1:0]  stall_cycles_q;
  logic                  load_use;

  // A load in EX whose destination feeds a live source of the instruction in ID.
  assign load_use = ex_mem_read & ~ex_no_op & (ex_reg_dest_idx != '0) &
                    ((id_uses_reg_1 & (id_reg_1_idx == ex_reg_dest_idx)) |
                     (id_uses_reg_2 & (id_reg_2_idx == ex_reg_dest_idx)));

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    pc_hold       = 1'b0;
    if_id_hazard  = 2'b00;
    id_ex_hazard  = 2'b00;
    ex_mem_hazard = 2'b00;
    mem_wb_hazard = 2'b00;
    mem_timeout   = 1'b0;

    case (state_q)
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          wait_d  = '0;
          state_d = ST_RUN;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
          mem_timeout = 1'b1;
          wait_d      = '0;
          state_d     = ST_RUN;
        end else begin
          pc_hold       = 1'b1;
          if_id_hazard  = HZ_HOLD;
          id_ex_hazard  = HZ_HOLD;
          ex_mem_hazard = HZ_HOLD;
          mem_wb_hazard = HZ_NO_OP;
          wait_d        = wait_q + WAIT_W'(1);
        end
      end
      default: begin
        // RUN, FLUSH and LOAD_USE share the priority chain; FLUSH masks branch and load-use,
        // LOAD_USE masks only load-use.
        state_d = ST_RUN;
        if (mem_stall_req) begin
          if (!mem_ready) begin
            pc_hold       = 1'b1;
            if_id_hazard  = HZ_HOLD;
            id_ex_hazard  = HZ_HOLD;
            ex_mem_hazard = HZ_HOLD;
            mem_wb_hazard = HZ_NO_OP;
            wait_d        = WAIT_W'(1);
            state_d       = ST_MEM_WAIT;
          end
        end else if (branch_taken && (state_q != ST_FLUSH)) begin
          if_id_hazard = HZ_NO_OP;
          id_ex_hazard = HZ_NO_OP;
          state_d      = ST_FLUSH;
        end else if (load_use && (state_q == ST_RUN)) begin
          pc_hold      = 1'b1;
          if_id_hazard = HZ_HOLD;
          id_ex_hazard = HZ_HOLD | HZ_NO_OP;
          state_d      = ST_LOAD_USE;
        end
      end
    endcase

    if (!rst_n) begin
      pc_hold       = 1'b0;
      if_id_hazard  = HZ_NO_OP;
      id_ex_hazard  = HZ_NO_OP;
      ex_mem_hazard = HZ_NO_OP;
      mem_wb_hazard = HZ_NO_OP;
      mem_timeout   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      wait_q         <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (pc_hold && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + CNT_WIDTH'(1);
      end
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized scoreboard bench for hazard_unit: a driver predicts each cycle's outputs from
// the sequencing rules and queues them; an independent monitor pops and compares.
module tb_hazard_unit;

  localparam int unsigned TMO = 4;
  localparam int unsigned CW  = 6;
  localparam int unsigned AW  = 5;
  localparam int          SAT = (1 << CW) - 1;

  typedef struct packed {
    logic          rst_n;
    logic [AW-1:0] id1;
    logic [AW-1:0] id2;
    logic          u1;
    logic          u2;
    logic [AW-1:0] exd;
    logic          mr;
    logic          nop;
    logic          br;
    logic          msr;
    logic          rdy;
  } stim_t;

  typedef struct packed {
    logic          pc_hold;
    logic [1:0]    if_id;
    logic [1:0]    id_ex;
    logic [1:0]    ex_mem;
    logic [1:0]    mem_wb;
    logic          tmo;
    logic [CW-1:0] stall;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] id_reg_1_idx, id_reg_2_idx, ex_reg_dest_idx;
  logic          id_uses_reg_1, id_uses_reg_2, ex_mem_read, ex_no_op;
  logic          branch_taken, mem_stall_req, mem_ready;
  logic          pc_hold, mem_timeout;
  logic [1:0]    if_id_hazard, id_ex_hazard, ex_mem_hazard, mem_wb_hazard;
  logic [CW-1:0] stall_cycles;

  hazard_unit #(.MEM_TIMEOUT(TMO), .CNT_WIDTH(CW), .REG_FILE_ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_reg_1_idx   (id_reg_1_idx),
    .id_reg_2_idx   (id_reg_2_idx),
    .id_uses_reg_1  (id_uses_reg_1),
    .id_uses_reg_2  (id_uses_reg_2),
    .ex_reg_dest_idx(ex_reg_dest_idx),
    .ex_mem_read    (ex_mem_read),
    .ex_no_op       (ex_no_op),
    .branch_taken   (branch_taken),
    .mem_stall_req  (mem_stall_req),
    .mem_ready      (mem_ready),
    .pc_hold        (pc_hold),
    .if_id_hazard   (if_id_hazard),
    .id_ex_hazard   (id_ex_hazard),
    .ex_mem_hazard  (ex_mem_hazard),
    .mem_wb_hazard  (mem_wb_hazard),
    .mem_timeout    (mem_timeout),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  // Reference state: elapsed MEM_WAIT cycles (0 = not waiting), one-cycle masks, stall tally.
  int   m_wait   = 0;
  bit   m_ign_br = 1'b0;
  bit   m_ign_lu = 1'b0;
  int   m_stalls = 0;

  function automatic stim_t idle();
    stim_t s;
    s       = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic exp_t freeze(input exp_t e);
    exp_t r;
    r         = e;
    r.pc_hold = 1'b1;
    r.if_id   = 2'b01;
    r.id_ex   = 2'b01;
    r.ex_mem  = 2'b01;
    r.mem_wb  = 2'b10;
    return r;
  endfunction

  task automatic cycle(input stim_t s, input bit check);
    exp_t e;
    bit   lu, nb, nl;
    @(negedge clk);
    rst_n           = s.rst_n;
    id_reg_1_idx    = s.id1;
    id_reg_2_idx    = s.id2;
    id_uses_reg_1   = s.u1;
    id_uses_reg_2   = s.u2;
    ex_reg_dest_idx = s.exd;
    ex_mem_read     = s.mr;
    ex_no_op        = s.nop;
    branch_taken    = s.br;
    mem_stall_req   = s.msr;
    mem_ready       = s.rdy;

    e       = '0;
    e.stall = CW'(m_stalls);
    if (!s.rst_n) begin
      e.if_id  = 2'b10;
      e.id_ex  = 2'b10;
      e.ex_mem = 2'b10;
      e.mem_wb = 2'b10;
      m_wait   = 0;
      m_ign_br = 1'b0;
      m_ign_lu = 1'b0;
      m_stalls = 0;
    end else begin
      lu = 1'b0;
      if (s.mr && !s.nop && s.exd != 0) begin
        if (s.u1 && s.id1 == s.exd) lu = 1'b1;
        if (s.u2 && s.id2 == s.exd) lu = 1'b1;
      end
      nb = 1'b0;
      nl = 1'b0;
      if (m_wait > 0) begin
        if (s.rdy) m_wait = 0;
        else if (m_wait == int'(TMO)) begin
          e.tmo  = 1'b1;
          m_wait = 0;
        end else begin
          e = freeze(e);
          m_wait++;
        end
      end else if (s.msr) begin
        if (!s.rdy) begin
          e      = freeze(e);
          m_wait = 1;
        end
      end else if (s.br && !m_ign_br) begin
        e.if_id = 2'b10;
        e.id_ex = 2'b10;
        nb      = 1'b1;
        nl      = 1'b1;
      end else if (lu && !m_ign_lu) begin
        e.pc_hold = 1'b1;
        e.if_id   = 2'b01;
        e.id_ex   = 2'b11;
        nl        = 1'b1;
      end
      m_ign_br = nb;
      m_ign_lu = nl;
      if (e.pc_hold && m_stalls < SAT) m_stalls++;
    end
    if (check) exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    cmp_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle once the inputs settle after the falling edge.
  exp_t me;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        me = exp_q.pop_front();
        chk("pc_hold",       32'(pc_hold),       32'(me.pc_hold));
        chk("if_id_hazard",  32'(if_id_hazard),  32'(me.if_id));
        chk("id_ex_hazard",  32'(id_ex_hazard),  32'(me.id_ex));
        chk("ex_mem_hazard", 32'(ex_mem_hazard), 32'(me.ex_mem));
        chk("mem_wb_hazard", 32'(mem_wb_hazard), 32'(me.mem_wb));
        chk("mem_timeout",   32'(mem_timeout),   32'(me.tmo));
        chk("stall_cycles",  32'(stall_cycles),  32'(me.stall));
      end
    end
  end

  initial begin
    #400000;
    err_cnt++;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", exp_q.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    int    rdy_pct;
    rst_n = 1'b0;
    {id_reg_1_idx, id_reg_2_idx, ex_reg_dest_idx} = '0;
    {id_uses_reg_1, id_uses_reg_2, ex_mem_read, ex_no_op} = '0;
    {branch_taken, mem_stall_req, mem_ready} = '0;

    // Reset: first cycle has unknown counter, second checks forced outputs.
    s = idle();
    s.rst_n = 1'b0;
    cycle(s, 1'b0);
    cycle(s, 1'b1);
    cycle(idle(), 1'b1);

    // Load-use on source 2, inputs held for the follow-up cycle.
    s = idle();
    s.mr = 1'b1; s.exd = 5'd5; s.id2 = 5'd5; s.u2 = 1'b1;
    cycle(s, 1'b1);
    cycle(s, 1'b1);
    cycle(idle(), 1'b1);

    // No stall for destination x0 or an unused matching source.
    s = idle();
    s.mr = 1'b1; s.exd = 5'd0; s.id2 = 5'd0; s.u2 = 1'b1;
    cycle(s, 1'b1);
    s = idle();
    s.mr = 1'b1; s.exd = 5'd7; s.id1 = 5'd7; s.u1 = 1'b0;
    cycle(s, 1'b1);

    // Branch taken held for two cycles; second is masked.
    s = idle();
    s.br = 1'b1;
    cycle(s, 1'b1);
    cycle(s, 1'b1);
    cycle(idle(), 1'b1);

    // Memory stall released by mem_ready after three held cycles.
    s = idle();
    s.msr = 1'b1;
    cycle(s, 1'b1);
    cycle(idle(), 1'b1);
    cycle(idle(), 1'b1);
    s = idle();
    s.rdy = 1'b1;
    cycle(s, 1'b1);

    // Stall request beats branch and load-use in the same cycle.
    s = idle();
    s.msr = 1'b1; s.br = 1'b1; s.mr = 1'b1; s.exd = 5'd3; s.id1 = 5'd3; s.u1 = 1'b1;
    cycle(s, 1'b1);
    s.msr = 1'b0;
    cycle(s, 1'b1);
    s.rdy = 1'b1;
    cycle(s, 1'b1);
    cycle(idle(), 1'b1);

    // Single-cycle access: request with ready.
    s = idle();
    s.msr = 1'b1; s.rdy = 1'b1;
    cycle(s, 1'b1);

    // Timeout with mem_ready never asserted.
    s = idle();
    s.msr = 1'b1;
    cycle(s, 1'b1);
    repeat (5) cycle(idle(), 1'b1);

    // Reset in the middle of MEM_WAIT.
    s = idle();
    s.msr = 1'b1;
    cycle(s, 1'b1);
    cycle(idle(), 1'b1);
    s = idle();
    s.rst_n = 1'b0;
    cycle(s, 1'b1);
    repeat (6) cycle(idle(), 1'b1);

    // Randomized traffic; ready probability alternates to reach both release paths.
    for (int i = 0; i < 3000; i++) begin
      rdy_pct = ((i / 200) % 2 == 0) ? 40 : 4;
      s.rst_n = ($urandom_range(0, 99) >= 1);
      s.id1   = AW'($urandom_range(0, 3));
      s.id2   = AW'($urandom_range(0, 3));
      s.u1    = 1'($urandom_range(0, 1));
      s.u2    = 1'($urandom_range(0, 1));
      s.exd   = AW'($urandom_range(0, 3));
      s.mr    = ($urandom_range(0, 99) < 50);
      s.nop   = ($urandom_range(0, 99) < 20);
      s.br    = ($urandom_range(0, 99) < 15);
      s.msr   = ($urandom_range(0, 99) < 10);
      s.rdy   = ($urandom_range(0, 99) < rdy_pct);
      cycle(s, 1'b1);
    end

    repeat (2) @(negedge clk);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
